// File: rtl/red_led_driver.sv
// Red-LED output stage: PWM dimming and hardware blink applied to the parallel-port
// LED word, configured through a small Avalon-MM register slave.
module red_led_driver #(
    parameter int unsigned DW       = 9,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW:0]   led_in,
    input  logic [1:0]    address,
    input  logic          chipselect,
    input  logic          read,
    input  logic          write,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic [DW:0]   LEDR
);

    localparam int unsigned LW         = DW + 1;
    localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]  DUTY_RST   = 8'hFF;
    localparam logic [15:0] PERIOD_RST = 16'd500;

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        PH_ON  = 2'd1,
        PH_OFF = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    duty_q, duty_d;
    logic [15:0]   period_q, period_d;
    logic          mode_q, mode_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   tick_cnt_q, tick_cnt_d;
    logic [31:0]   readdata_q, readdata_d;
    logic [DW:0]   ledr_q, ledr_d;

    logic          reg_we;
    logic          cfg_wr;
    logic          tick;
    logic          restart;
    logic          pwm_on;
    logic          phase_on;
    logic [31:0]   rdata;
    logic          unused_in;

    assign reg_we    = chipselect & write;
    assign cfg_wr    = reg_we & ((address == 2'd1) | (address == 2'd2));
    assign tick      = (presc_q == PRESC_MAX);
    assign pwm_on    = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
    assign phase_on  = (state_q != PH_OFF);
    assign unused_in = ^{read, writedata[31:16]};

    assign readdata  = readdata_q;
    assign LEDR      = ledr_q;

    // Register file writes; address 3 is read-only
    always_comb begin
        duty_d   = duty_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (reg_we) begin
            case (address)
                2'd0:    duty_d   = writedata[7:0];
                2'd1:    period_d = (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
                2'd2:    mode_d   = writedata[0];
                default: ;
            endcase
        end
    end

    // Blink FSM; decisions use the post-write MODE so a mode write acts on the next edge
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        restart    = 1'b0;
        if (!mode_d) begin
            state_d    = STEADY;
            tick_cnt_d = 16'd0;
        end else if ((state_q == STEADY) || cfg_wr) begin
            state_d    = PH_ON;
            tick_cnt_d = 16'd0;
            restart    = 1'b1;
        end else if (tick) begin
            if (tick_cnt_q >= 16'(period_q - 16'd1)) begin
                state_d    = (state_q == PH_ON) ? PH_OFF : PH_ON;
                tick_cnt_d = 16'd0;
            end else begin
                tick_cnt_d = tick_cnt_q + 16'd1;
            end
        end
    end

    // Prescaler realigns on phase restart so every phase is exactly PERIOD*TICK_DIV clocks
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        presc_d   = tick ? '0 : presc_q + PW'(1);
        if (restart) begin
            presc_d = '0;
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            2'd0:    rdata[7:0]  = duty_q;
            2'd1:    rdata[15:0] = period_q;
            2'd2:    rdata[0]    = mode_q;
            default: rdata[1:0]  = {pwm_on, phase_on};
        endcase
        readdata_d = chipselect ? rdata : readdata_q;
        ledr_d     = led_in & {LW{pwm_on & phase_on}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= STEADY;
            duty_q     <= DUTY_RST;
            period_q   <= PERIOD_RST;
            mode_q     <= 1'b0;
            pwm_cnt_q  <= 8'd0;
            presc_q    <= '0;
            tick_cnt_q <= 16'd0;
            readdata_q <= 32'd0;
            ledr_q     <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            mode_q     <= mode_d;
            pwm_cnt_q  <= pwm_cnt_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            readdata_q <= readdata_d;
            ledr_q     <= ledr_d;
        end
    end

endmodule

// File: tb/tb_red_led_driver.sv
// Scoreboard bench for red_led_driver: stimulus queues expected reads/LED values,
// a negedge monitor pops and compares when the delayed strobes say output is due.
module tb_red_led_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  led_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    wire  [31:0] readdata;
    wire  [9:0]  LEDR;

    logic led_smp, cnt_en, cnt_done;
    logic rd_vld = 1'b0, led_vld = 1'b0, cnt_vld = 1'b0, done_vld = 1'b0;

    logic [31:0] rd_q[$];
    logic [9:0]  led_q[$];
    int          cnt_exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          on_cnt  = 0;

    red_led_driver #(.DW(9), .TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_in),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .LEDR       (LEDR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output-due strobes: a read or LED sample issued in cycle c is visible after edge c+1
    always @(posedge clk) begin
        rd_vld   <= chipselect & read;
        led_vld  <= led_smp;
        cnt_vld  <= cnt_en;
        done_vld <= cnt_done;
    end

    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_q.size() == 0) check("rd_queue_underflow", 32'd1, 32'd0);
            else                  check("readdata", readdata, rd_q.pop_front());
        end
        if (led_vld) begin
            if (led_q.size() == 0) check("led_queue_underflow", 32'd1, 32'd0);
            else                   check("ledr", 32'(LEDR), 32'(led_q.pop_front()));
        end
        if (cnt_vld && (LEDR != 10'd0)) on_cnt++;
        if (done_vld) begin
            if (cnt_exp_q.size() == 0) check("cnt_queue_underflow", 32'd1, 32'd0);
            else                       check("pwm_on_count", 32'(on_cnt), 32'(cnt_exp_q.pop_front()));
            on_cnt = 0;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        led_smp    = 1'b0;
        cnt_en     = 1'b0;
        cnt_done   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        next_cyc(); idle();
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        next_cyc(); idle();
        chipselect = 1'b1; read = 1'b1; address = a;
        rd_q.push_back(exp);
    endtask

    task automatic led(input logic [9:0] v, input logic [9:0] exp);
        next_cyc(); idle();
        led_in = v; led_smp = 1'b1;
        led_q.push_back(exp);
    endtask

    task automatic pwm_win(input int exp);
        for (int i = 0; i < 256; i++) begin
            next_cyc(); idle();
            cnt_en = 1'b1;
        end
        next_cyc(); idle();
        cnt_done = 1'b1;
        cnt_exp_q.push_back(exp);
    endtask

    // Cycle 0 issues the config write; with TICK_DIV=4, PERIOD=3 phases alternate every 12 cycles
    task automatic blink(input logic [1:0] a, input logic [31:0] d, input bit first_on, input int n);
        bit on;
        for (int i = 0; i < n; i++) begin
            next_cyc(); idle();
            on = (i == 0) ? first_on : (((i - 1) / 12) % 2 == 0);
            chipselect = 1'b1;
            if (i == 0) begin
                write = 1'b1; address = a; writedata = d;
            end else begin
                read = 1'b1; address = 2'd3;
                rd_q.push_back({30'd0, 1'b1, on});
            end
            led_smp = 1'b1;
            led_q.push_back(on ? led_in : 10'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; led_in = 10'h000; address = 2'd0; writedata = 32'd0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ledr", 32'(LEDR), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        #2 reset = 1'b1;
        led_in = 10'h2AA;
        #1 check("rel_ledr", 32'(LEDR), 32'd0);

        rd(2'd0, 32'h0000_00FF);
        rd(2'd1, 32'd500);
        rd(2'd2, 32'd0);
        rd(2'd3, 32'd3);

        led(10'h2AA, 10'h2AA);
        led(10'h155, 10'h155);
        led(10'h0F0, 10'h0F0);
        led(10'h2AA, 10'h2AA);

        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd0, 32'h0000_00FF);
        rd(2'd1, 32'd500);
        rd(2'd2, 32'd0);

        wr(2'd1, 32'd0);
        rd(2'd1, 32'd1);

        wr(2'd0, 32'h40);
        pwm_win(64);
        wr(2'd0, 32'h0);
        rd(2'd0, 32'd0);
        pwm_win(0);
        wr(2'd0, 32'hFF);
        pwm_win(256);

        wr(2'd1, 32'd3);
        blink(2'd2, 32'd1, 1'b1, 48);
        blink(2'd1, 32'd3, 1'b0, 30);
        wr(2'd2, 32'd0);
        led(10'h2AA, 10'h2AA);
        rd(2'd3, 32'd3);

        wr(2'd0, 32'hFE);
        wr(2'd1, 32'd7);
        wr(2'd2, 32'd1);
        rd(2'd2, 32'd1);
        next_cyc(); idle();
        next_cyc();
        #2 reset = 1'b0;
        #1;
        check("midrst_ledr", 32'(LEDR), 32'd0);
        check("midrst_readdata", readdata, 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("midrst_rel_ledr", 32'(LEDR), 32'd0);
        rd(2'd0, 32'h0000_00FF);
        rd(2'd1, 32'd500);
        rd(2'd2, 32'd0);
        led(10'h2AA, 10'h2AA);

        next_cyc(); idle();
        repeat (3) next_cyc();
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("led_q_drained", 32'(led_q.size()), 32'd0);
        check("cnt_q_drained", 32'(cnt_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
